// File: rtl/mux_nto1_arb.sv
// mux_nto1_arb
//   N-input, WIDTH-bit registered multiplexer with per-channel valid/ready.
//   One requesting channel is granted per cycle, chosen by fixed priority
//   (MODE=0, lowest index wins) or round-robin (MODE=1). The chosen word is
//   captured into an output register, which isolates producer and consumer
//   timing.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    N*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   N, channel i offers a word
//   in_ready   N, one-hot or zero; channel i accepted on in_valid[i] & in_ready[i]
//   out_data   WIDTH, registered selected word
//   out_valid  out_data holds a word
//   out_ready  consumer accepts on out_valid & out_ready
//   out_sel    SELW, channel index that supplied out_data
module mux_nto1_arb #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = 1,
  localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [N-1:0][WIDTH-1:0] in_arr;
  logic [SELW-1:0]         rr_ptr;
  logic [SELW-1:0]         scan_idx;
  logic [SELW-1:0]         gnt_idx;
  logic                    gnt_found;
  logic                    load;

  assign in_arr = in_data;

  // Output register may take a new word when empty or being drained.
  assign load = ~out_valid | out_ready;

  // Index after i, wrapping explicitly at N-1 (N need not be a power of 2).
  function automatic logic [SELW-1:0] nxt(input logic [SELW-1:0] i);
    return (i == LAST) ? '0 : i + SELW'(1);
  endfunction

  // Walk all N channels starting at the priority head; first requester wins.
  // Fixed priority is the same walk with the head pinned at 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = (MODE == 1) ? rr_ptr : '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_found && in_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
      scan_idx = nxt(scan_idx);
    end
    if (!load || rst) gnt_found = 1'b0;
  end

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = gnt_found && (gnt_idx == SELW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (gnt_found) begin
        out_data  <= in_arr[gnt_idx];
        out_sel   <= gnt_idx;
        out_valid <= 1'b1;
        // Pointer moves past the winner only on a real grant.
        if (MODE == 1) rr_ptr <= nxt(gnt_idx);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_arb.sv
module tb_mux_nto1_arb;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic           out_ready;

  // index 0: fixed-priority instance, index 1: round-robin instance
  logic [N-1:0] rdy [2];
  logic [W-1:0] od  [2];
  logic         ov  [2];
  logic [1:0]   os  [2];

  int tests = 0;
  int fails = 0;

  typedef struct { logic [W-1:0] d; int s; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   m_ptr [2];
  bit   m_ov  [2];

  mux_nto1_arb #(.WIDTH(W), .N(N), .MODE(0)) u_fp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .out_sel(os[0]));

  mux_nto1_arb #(.WIDTH(W), .N(N), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .out_sel(os[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference arbitration: first valid channel in priority order.
  function automatic int pick(input int mode, input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mode == 1) ? (ptr + k) % N : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Model: predicts in_ready and out_valid, pushes accepted words.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int            g;
      bit            ld;
      logic [N-1:0]  er;
      exp_t          e;
      chk($sformatf("out_valid_m%0d", m), 64'(ov[m]), 64'(m_ov[m]));
      er = '0;
      if (rst) begin
        m_ov[m]  = 1'b0;
        m_ptr[m] = 0;
        if (m == 0) q0.delete(); else q1.delete();
      end else begin
        ld = !m_ov[m] || out_ready;
        g  = ld ? pick(m, m_ptr[m], in_valid) : -1;
        if (g >= 0) begin
          er   = N'(1) << g;
          e.d  = in_data[g*W +: W];
          e.s  = g;
          if (m == 0) q0.push_back(e); else q1.push_back(e);
          m_ov[m] = 1'b1;
          if (m == 1) m_ptr[m] = (g + 1) % N;
        end else if (ld) begin
          m_ov[m] = 1'b0;
        end
      end
      chk($sformatf("in_ready_m%0d", m), 64'(rdy[m]), 64'(er));
    end
  end

  // Monitor: on each output handshake the oldest accepted word must appear.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      exp_t e;
      int   sz;
      if (!rst && ov[m] === 1'b1 && out_ready) begin
        sz = (m == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_empty_m%0d actual=word sel %0d required=no word", m, os[m]);
        end else begin
          if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk($sformatf("sb_data_m%0d", m), 64'(od[m]), 64'(e.d));
          chk($sformatf("sb_sel_m%0d", m),  64'(os[m]), 64'(e.s));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    in_data   = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};

    // Reset held with all channels requesting
    repeat (3) cyc();
    for (int m = 0; m < 2; m++) begin
      chk("rst_out_valid", 64'(ov[m]), 64'd0);
      chk("rst_out_data",  64'(od[m]), 64'd0);
      chk("rst_out_sel",   64'(os[m]), 64'd0);
      chk("rst_in_ready",  64'(rdy[m]), 64'd0);
    end

    // Fixed priority: ch1 beats ch3 every cycle
    rst      = 1'b0;
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("fp_sel",  64'(os[0]), 64'd1);
      chk("fp_data", 64'(od[0]), 64'h11111111);
    end

    // Round-robin from a fresh pointer
    rst = 1'b1; cyc(); rst = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rr_seq", 64'(os[1]), 64'(k % 4));
    end

    // Backpressure: held word stays put, then pass-through with no bubble
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_sel",  64'(os[1]), 64'd3);
      chk("bp_data", 64'(od[1]), 64'h33333333);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_release_sel",   64'(os[1]), 64'd0);
    chk("bp_release_valid", 64'(ov[1]), 64'd1);

    // Sparse round-robin with wrap
    rst = 1'b1; cyc(); rst = 1'b0;
    in_valid = 4'b0100; cyc(); chk("sparse_ch2", 64'(os[1]), 64'd2);
    in_valid = 4'b0001; cyc(); chk("sparse_ch0", 64'(os[1]), 64'd0);
    in_valid = 4'b1111; cyc(); chk("sparse_ch1", 64'(os[1]), 64'd1);

    // Reset while a word is held under backpressure
    out_ready = 1'b0; cyc();
    rst = 1'b1; cyc();
    chk("midrst_valid", 64'(ov[1]), 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    cyc(); chk("midrst_first",  64'(os[1]), 64'd0);
    cyc(); chk("midrst_second", 64'(os[1]), 64'd1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end

    // Drain
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
